control_unit_mc: RTL and testbench
==================================

// Module: control_unit_mc
// PURPOSE
//  Multicycle K&S control FSM, next generation. Sequences fetch/decode/execute for the
//  k_and_s_pkg instruction set and drives the datapath enables.
//  Adds a parametrised RAM read-latency wait counter, a retired-instruction counter,
//  and a debug single-step mode.
//  Sits between the datapath (decoded_instruction, flag inputs) and the RAM/PC/IR/regfile enables.
// PARAMETERS
//  MEM_WAIT  2   extra RAM read wait cycles before load write-back (0..15; 0 = none)
//  CNT_W     16  width of retired_count
// PORTS
//  clk                 in   1      clock, all state on rising edge
//  rst                 in   1      synchronous reset, active-high
//  decoded_instruction in   enum   decoded_instruction_type from k_and_s_pkg
//  zero_op             in   1      registered zero flag from datapath
//  neg_op              in   1      registered negative flag
//  unsigned_overflow   in   1      registered unsigned overflow flag (monitor only)
//  signed_overflow     in   1      registered signed overflow flag (monitor only)
//  step_mode           in   1      1 = stop after each retired instruction
//  resume              in   1      1-cycle pulse releasing a step stop
//  branch              out  1      PC loads branch target
//  pc_enable           out  1      PC update strobe
//  ir_enable           out  1      IR load strobe
//  write_reg_enable    out  1      register file write
//  addr_sel            out  1      1 = RAM address from PC, 0 = from instruction operand
//  c_sel               out  1      0 = write-back from ALU, 1 = from RAM
//  operation           out  2      ALU op: 00 OR/MOVE, 01 ADD, 10 SUB, 11 AND
//  flags_reg_enable    out  1      flag register load
//  ram_write_enable    out  1      RAM write strobe
//  halt                out  1      processor halted
//  retired_count       out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - Reset: state <= FETCH, operation <= 00, wait counter <= 0, retired_count <= 0.
//    While rst=1 every 1-bit output is forced 0. Reset mid-instruction aborts it
//    with no write or strobe issued on the cycle after the reset edge.
//  - Moore outputs decoded from state. Signals not listed for a state are 0.
//    FETCH: addr_sel, ir_enable   DECODE: addr_sel   EXEC: flags_reg_enable (not for MOVE)
//    WB: write_reg_enable, c_sel=0   MEM_ADDR/MEM_WAIT: addr_sel=0
//    WB_LOAD: c_sel, write_reg_enable   W_MEM: ram_write_enable
//    BRANCH: branch, pc_enable, addr_sel   PC_EN: pc_enable, addr_sel
//    STEP_HOLD: addr_sel   HALT: halt
//  - operation: a register loaded only in DECODE for ADD/SUB/AND/OR/MOVE; held otherwise.
//  - Transitions:
//    FETCH->DECODE. DECODE by instruction:
//      ALU ops->EXEC->WB->PC_EN
//      LOAD->MEM_ADDR->MEM_WAIT (MEM_WAIT cycles; skipped if 0)->WB_LOAD->PC_EN
//      STORE->MEM_ADDR->W_MEM->PC_EN
//      BRANCH->BRANCH
//      BZERO/BNZERO/BNEG/BNNEG->BRANCH if condition true, else PC_EN (flags sampled in DECODE)
//      NOP and any unlisted encoding->PC_EN
//      HALT->HALT
//    BRANCH/PC_EN -> STEP_HOLD if step_mode, else FETCH.
//    STEP_HOLD -> FETCH on resume=1.
//    HALT is absorbing; only rst leaves it, and resume is ignored there.
//  - Latency: ALU and STORE take 5 cycles, LOAD 5+MEM_WAIT, branch/NOP 3.
//  - retired_count increments by 1 on each cycle with pc_enable=1 and wraps modulo 2^CNT_W.
//    HALT does not count.
//  - A resume pulse outside STEP_HOLD has no effect and is not stored.
//  - step_mode is sampled only on leaving BRANCH/PC_EN.
//  - branch and ram_write_enable are never high simultaneously.
// TESTING
//  - ADD after reset -> ir_enable cycle 1, flags_reg_enable cycle 3, write_reg_enable cycle 4,
//    pc_enable cycle 5, operation=01, retired_count=1.
//  - LOAD, MEM_WAIT=2 -> addr_sel=0 cycles 3-5, c_sel=write_reg_enable=1 cycle 6,
//    pc_enable cycle 7.
//  - BZERO zero_op=1 -> branch=pc_enable=1 cycle 3; zero_op=0 -> branch=0, pc_enable=1 cycle 3.
//  - step_mode=1, two NOPs -> stops in STEP_HOLD with retired_count=1;
//    resume 4 cycles later -> next FETCH follows; retired_count=2 after second NOP.
//  - HALT then resume pulses -> halt stays 1, retired_count frozen; rst=1 one cycle ->
//    halt=0, count 0.
//  - rst asserted during W_MEM -> ram_write_enable=0 next cycle; CNT_W=2 with 5 NOPs ->
//    retired_count=1 (wrap).

Source files
------------

// File: rtl/control_unit_mc.sv
// Multicycle K&S control FSM: sequences fetch/decode/execute and drives the
// datapath enables. Adds a RAM read-latency wait counter, a retired-instruction
// counter and a debug single-step hold.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

module control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    step_mode,
  input  logic                    resume,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        retired_count
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_MEM_ADDR,
    S_MEM_WAIT,
    S_WB_LOAD,
    S_W_MEM,
    S_BRANCH,
    S_PC_EN,
    S_STEP_HOLD,
    S_HALT
  } state_t;

  // Wait counter counts down to zero, so it is preloaded with one less than
  // the number of wait cycles wanted.
  localparam logic [3:0] WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [1:0] op_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       is_move, is_move_nxt;
  logic       is_store, is_store_nxt;

  // Overflow flags are carried to this block for monitoring only.
  logic unused_flags;
  assign unused_flags = unsigned_overflow ^ signed_overflow;

  // State, ALU operation, wait counter, instruction flavour and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state         <= S_FETCH;
      operation     <= 2'b00;
      wait_cnt      <= 4'd0;
      is_move       <= 1'b0;
      is_store      <= 1'b0;
      retired_count <= '0;
    end else begin
      state     <= state_nxt;
      operation <= op_nxt;
      wait_cnt  <= wait_cnt_nxt;
      is_move   <= is_move_nxt;
      is_store  <= is_store_nxt;
      if (pc_enable) retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Next-state logic; also decides the ALU operation and flavour bits in DECODE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    op_nxt       = operation;
    wait_cnt_nxt = wait_cnt;
    is_move_nxt  = is_move;
    is_store_nxt = is_store;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        is_move_nxt  = 1'b0;
        is_store_nxt = 1'b0;
        case (decoded_instruction)
          I_ADD:    begin op_nxt = 2'b01; state_nxt = S_EXEC; end
          I_SUB:    begin op_nxt = 2'b10; state_nxt = S_EXEC; end
          I_AND:    begin op_nxt = 2'b11; state_nxt = S_EXEC; end
          I_OR:     begin op_nxt = 2'b00; state_nxt = S_EXEC; end
          I_MOVE:   begin op_nxt = 2'b00; is_move_nxt = 1'b1; state_nxt = S_EXEC; end
          I_LOAD:   state_nxt = S_MEM_ADDR;
          I_STORE:  begin is_store_nxt = 1'b1; state_nxt = S_MEM_ADDR; end
          I_BRANCH: state_nxt = S_BRANCH;
          I_BZERO:  state_nxt = zero_op  ? S_BRANCH : S_PC_EN;
          I_BNZERO: state_nxt = !zero_op ? S_BRANCH : S_PC_EN;
          I_BNEG:   state_nxt = neg_op   ? S_BRANCH : S_PC_EN;
          I_BNNEG:  state_nxt = !neg_op  ? S_BRANCH : S_PC_EN;
          I_HALT:   state_nxt = S_HALT;
          default:  state_nxt = S_PC_EN;
        endcase
      end
      S_EXEC: state_nxt = S_WB;
      S_WB:   state_nxt = S_PC_EN;
      S_MEM_ADDR: begin
        if (is_store) begin
          state_nxt = S_W_MEM;
        end else if (MEM_WAIT == 0) begin
          state_nxt = S_WB_LOAD;
        end else begin
          state_nxt    = S_MEM_WAIT;
          wait_cnt_nxt = WAIT_INIT;
        end
      end
      S_MEM_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_WB_LOAD;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_WB_LOAD: state_nxt = S_PC_EN;
      S_W_MEM:   state_nxt = S_PC_EN;
      S_BRANCH,
      S_PC_EN:     state_nxt = step_mode ? S_STEP_HOLD : S_FETCH;
      S_STEP_HOLD: if (resume) state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Moore output decode; everything is held low while reset is asserted.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH:     begin addr_sel = 1'b1; ir_enable = 1'b1; end
        S_DECODE:    addr_sel = 1'b1;
        S_EXEC:      flags_reg_enable = !is_move;
        S_WB:        write_reg_enable = 1'b1;
        S_WB_LOAD:   begin c_sel = 1'b1; write_reg_enable = 1'b1; end
        S_W_MEM:     ram_write_enable = 1'b1;
        S_BRANCH:    begin branch = 1'b1; pc_enable = 1'b1; addr_sel = 1'b1; end
        S_PC_EN:     begin pc_enable = 1'b1; addr_sel = 1'b1; end
        S_STEP_HOLD: addr_sel = 1'b1;
        S_HALT:      halt = 1'b1;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: two instances (MEM_WAIT=2/CNT_W=16 and
// MEM_WAIT=0/CNT_W=2) share one directed stimulus. A cycle-index model of the
// instruction timing predicts every output each cycle; literal checks pin the
// key timing points.

module tb_control_unit_mc;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, zero_op, neg_op, uov, sov, step_mode, resume;
  decoded_instruction_type ins;

  logic a_br, a_pc, a_ir, a_wr, a_as, a_cs, a_fe, a_rw, a_ht;
  logic b_br, b_pc, b_ir, b_wr, b_as, b_cs, b_fe, b_rw, b_ht;
  logic [1:0]  a_op, b_op;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  control_unit_mc #(.MEM_WAIT(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .decoded_instruction(ins), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(uov), .signed_overflow(sov), .step_mode(step_mode), .resume(resume),
    .branch(a_br), .pc_enable(a_pc), .ir_enable(a_ir), .write_reg_enable(a_wr),
    .addr_sel(a_as), .c_sel(a_cs), .operation(a_op), .flags_reg_enable(a_fe),
    .ram_write_enable(a_rw), .halt(a_ht), .retired_count(a_cnt));

  control_unit_mc #(.MEM_WAIT(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .decoded_instruction(ins), .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(uov), .signed_overflow(sov), .step_mode(step_mode), .resume(resume),
    .branch(b_br), .pc_enable(b_pc), .ir_enable(b_ir), .write_reg_enable(b_wr),
    .addr_sel(b_as), .c_sel(b_cs), .operation(b_op), .flags_reg_enable(b_fe),
    .ram_write_enable(b_rw), .halt(b_ht), .retired_count(b_cnt));

  logic [10:0] out_a, out_b;
  assign out_a = {a_br, a_pc, a_ir, a_wr, a_as, a_cs, a_op, a_fe, a_rw, a_ht};
  assign out_b = {b_br, b_pc, b_ir, b_wr, b_as, b_cs, b_op, b_fe, b_rw, b_ht};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- timing model ----------------
  // Each instance tracks the cycle index within the current instruction
  // (1 = fetch, 2 = decode) and knows the instruction length from its class.
  int                      m_k     [2];
  bit                      m_halt  [2];
  bit                      m_hold  [2];
  bit                      m_taken [2];
  decoded_instruction_type m_ins   [2];
  logic [1:0]              m_op    [2];
  int unsigned             m_cnt   [2];
  bit                      m_started = 1'b0;

  function automatic int mem_wait_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int unsigned cnt_mask_of(int i);
    return (i == 0) ? 32'hFFFF : 32'h3;
  endfunction

  function automatic bit is_alu(decoded_instruction_type d);
    return d inside {I_ADD, I_SUB, I_AND, I_OR, I_MOVE};
  endfunction

  function automatic int length_of(decoded_instruction_type d, int mw);
    if (is_alu(d) || d == I_STORE) return 5;
    if (d == I_LOAD) return 5 + mw;
    return 3;
  endfunction

  function automatic bit taken_of(decoded_instruction_type d, logic z, logic n);
    case (d)
      I_BRANCH: return 1'b1;
      I_BZERO:  return z;
      I_BNZERO: return !z;
      I_BNEG:   return n;
      I_BNNEG:  return !n;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [10:0] exp_out(int i);
    logic b, p, r, w, a, c, f, m, h;
    int   len;
    {b, p, r, w, a, c, f, m, h} = '0;
    if (!rst) begin
      if (m_halt[i]) h = 1'b1;
      else if (m_hold[i]) a = 1'b1;
      else if (m_k[i] == 1) begin a = 1'b1; r = 1'b1; end
      else if (m_k[i] == 2) a = 1'b1;
      else begin
        len = length_of(m_ins[i], mem_wait_of(i));
        if (m_k[i] == len) begin
          p = 1'b1; a = 1'b1; b = m_taken[i];
        end else if (is_alu(m_ins[i])) begin
          if (m_k[i] == 3) f = (m_ins[i] != I_MOVE);
          if (m_k[i] == 4) w = 1'b1;
        end else if (m_ins[i] == I_LOAD) begin
          if (m_k[i] == len - 1) begin c = 1'b1; w = 1'b1; end
        end else if (m_ins[i] == I_STORE) begin
          if (m_k[i] == 4) m = 1'b1;
        end
      end
    end
    return {b, p, r, w, a, c, m_op[i], f, m, h};
  endfunction

  // Model update on each rising edge, from the inputs the DUTs sample there.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_k[i] = 1; m_halt[i] = 1'b0; m_hold[i] = 1'b0; m_cnt[i] = 0;
        m_op[i] = 2'b00; m_ins[i] = I_NOP; m_taken[i] = 1'b0;
        m_started = 1'b1;
      end else if (m_halt[i]) begin
        // halted: nothing changes until reset
      end else if (m_hold[i]) begin
        if (resume) begin m_hold[i] = 1'b0; m_k[i] = 1; end
      end else if (m_k[i] == 2) begin
        m_ins[i]   = ins;
        m_taken[i] = taken_of(ins, zero_op, neg_op);
        case (ins)
          I_ADD:        m_op[i] = 2'b01;
          I_SUB:        m_op[i] = 2'b10;
          I_AND:        m_op[i] = 2'b11;
          I_OR, I_MOVE: m_op[i] = 2'b00;
          default:      ;
        endcase
        if (ins == I_HALT) m_halt[i] = 1'b1;
        m_k[i] = 3;
      end else if (m_k[i] == length_of(m_ins[i], mem_wait_of(i))) begin
        m_cnt[i] = (m_cnt[i] + 1) & cnt_mask_of(i);
        if (step_mode) m_hold[i] = 1'b1;
        else m_k[i] = 1;
      end else begin
        m_k[i]++;
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("dut_a outputs", {21'd0, out_a}, {21'd0, exp_out(0)});
      check("dut_a retired_count", {16'd0, a_cnt}, m_cnt[0]);
      check("dut_b outputs", {21'd0, out_b}, {21'd0, exp_out(1)});
      check("dut_b retired_count", {30'd0, b_cnt}, m_cnt[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input decoded_instruction_type d, input int cycles);
    ins = d;
    repeat (cycles) tick();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  decoded_instruction_type unk;

  initial begin
    rst = 1'b1; ins = I_NOP; zero_op = 1'b0; neg_op = 1'b0; uov = 1'b0; sov = 1'b0;
    step_mode = 1'b0; resume = 1'b0;
    unk = decoded_instruction_type'(4'd14);

    tick(); tick();
    @(negedge clk);
    check("reset ir_enable", a_ir, 1'b0);
    check("reset halt", a_ht, 1'b0);
    check("reset operation", a_op, 2'b00);
    check("reset retired_count", a_cnt, 16'd0);
    tick();

    // ADD after reset: cycle 1 begins now
    rst = 1'b0; ins = I_ADD;
    @(negedge clk); check("add ir_enable c1", a_ir, 1'b1);
    tick(); tick();
    @(negedge clk); check("add flags_reg_enable c3", a_fe, 1'b1);
    tick();
    @(negedge clk); check("add write_reg_enable c4", a_wr, 1'b1);
    check("add c_sel c4", a_cs, 1'b0);
    tick();
    @(negedge clk); check("add pc_enable c5", a_pc, 1'b1);
    check("add operation", a_op, 2'b01);
    tick();
    @(negedge clk); check("add retired_count", a_cnt, 16'd1);

    // remaining ALU ops, store, unconditional branch
    run(I_SUB, 5); run(I_AND, 5);
    @(negedge clk); check("and operation", a_op, 2'b11);
    run(I_OR, 5); run(I_MOVE, 5); run(I_STORE, 5); run(I_BRANCH, 3);

    // conditional branches
    zero_op = 1'b1; ins = I_BZERO;
    tick(); tick();
    @(negedge clk); check("bzero taken branch", a_br, 1'b1);
    check("bzero taken pc_enable", a_pc, 1'b1);
    tick();
    zero_op = 1'b0; ins = I_BZERO;
    tick(); tick();
    @(negedge clk); check("bzero not taken branch", a_br, 1'b0);
    check("bzero not taken pc_enable", a_pc, 1'b1);
    tick();
    neg_op = 1'b1; run(I_BNEG, 3); run(I_BNNEG, 3);
    run(I_BNZERO, 3);
    neg_op = 1'b0; run(I_BNNEG, 3);
    zero_op = 1'b1; run(I_BNZERO, 3);
    run(unk, 3); run(I_NOP, 3);

    // single-step: two NOPs with a stray resume during the first fetch
    do_reset();
    step_mode = 1'b1; ins = I_NOP; resume = 1'b1;
    tick(); resume = 1'b0;
    tick();
    @(negedge clk); check("step nop pc_enable c3", a_pc, 1'b1);
    tick();
    @(negedge clk); check("step hold addr_sel", a_as, 1'b1);
    check("step hold ir_enable", a_ir, 1'b0);
    check("step hold retired_count", a_cnt, 16'd1);
    repeat (3) tick();
    resume = 1'b1; tick(); resume = 1'b0;
    @(negedge clk); check("step resume fetch", a_ir, 1'b1);
    tick(); tick(); tick();
    @(negedge clk); check("step second hold count", a_cnt, 16'd2);
    check("step second hold pc_enable", a_pc, 1'b0);
    step_mode = 1'b0; resume = 1'b1; tick(); resume = 1'b0;

    // five NOPs: 2-bit counter wraps to 1
    do_reset();
    repeat (5) run(I_NOP, 3);
    @(negedge clk); check("wrap dut_b retired_count", b_cnt, 2'd1);
    check("wrap dut_a retired_count", a_cnt, 16'd5);

    // LOAD with MEM_WAIT=2 (dut_a) and MEM_WAIT=0 (dut_b)
    do_reset();
    ins = I_LOAD;
    tick(); tick();
    @(negedge clk); check("load addr_sel c3", a_as, 1'b0);
    tick();
    @(negedge clk); check("load addr_sel c4", a_as, 1'b0);
    check("load nowait c_sel c4", b_cs, 1'b1);
    tick();
    @(negedge clk); check("load addr_sel c5", a_as, 1'b0);
    check("load nowait pc_enable c5", b_pc, 1'b1);
    tick();
    @(negedge clk); check("load c_sel c6", a_cs, 1'b1);
    check("load write_reg_enable c6", a_wr, 1'b1);
    tick();
    @(negedge clk); check("load pc_enable c7", a_pc, 1'b1);
    ins = I_NOP;

    // reset asserted during W_MEM
    do_reset();
    ins = I_STORE;
    tick(); tick(); tick();
    @(negedge clk); check("store ram_write_enable c4", a_rw, 1'b1);
    check("store branch c4", a_br, 1'b0);
    #2 rst = 1'b1;
    tick();
    @(negedge clk); check("abort ram_write_enable", a_rw, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk); check("abort no write after release", a_rw, 1'b0);
    check("abort restarts at fetch", a_ir, 1'b1);

    // HALT absorbs resume pulses; reset releases it
    ins = I_NOP;
    tick(); tick(); tick();
    ins = I_HALT;
    tick(); tick();
    @(negedge clk); check("halt asserted", a_ht, 1'b1);
    check("halt count", a_cnt, 16'd1);
    repeat (3) begin
      resume = 1'b1; tick(); resume = 1'b0; tick();
    end
    @(negedge clk); check("halt held after resume", a_ht, 1'b1);
    check("halt pc_enable", a_pc, 1'b0);
    check("halt count frozen", a_cnt, 16'd1);
    tick();
    rst = 1'b1;
    @(negedge clk); check("halt forced low in reset", a_ht, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk); check("halt cleared", a_ht, 1'b0);
    check("count cleared", a_cnt, 16'd0);
    check("fetch after halt reset", a_ir, 1'b1);
    run(I_NOP, 4);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
